execute_muldiv_unit: RTL



---
 rtl/execute_muldiv_unit_if.sv | 24 ++
 rtl/execute_muldiv_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_unit_if.sv
// Execute-stage M-extension handshake: pipeline drives the op and operands,
// the unit answers with a combinational stall, a one-cycle done and the result.
interface execute_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] opa;
    logic [DATA_WIDTH-1:0] opb;
    logic                  stall;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output flush, start, op, opa, opb,
        input  stall, done, result
    );

    modport slave (
        input  flush, start, op, opa, opb,
        output stall, done, result
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// RV32M multiply/divide: MUL* holds EX 3 cycles, DIV* 34 (2 on div-by-zero/overflow).
// Backpressure is a combinational stall to the hazard unit; it drops on the done cycle.
module execute_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    execute_muldiv_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [1:0]      op_q;
    logic [W:0]      mul_a;
    logic [W:0]      mul_b;
    logic [W-1:0]    dvd;
    logic [W-1:0]    dvs;
    logic [W-1:0]    rem;
    logic [CW-1:0]   cnt;
    logic            q_neg;
    logic            r_neg;
    logic            done_q;
    logic [W-1:0]    result_q;

    logic            accept;
    logic            div_signed;
    logic            div_by_zero;
    logic            div_ovf;
    logic            a_signed;
    logic            b_signed;
    logic            cnt_last;
    logic [2*W-1:0]  ext_a;
    logic [2*W-1:0]  ext_b;
    logic [2*W-1:0]  product;
    logic [W:0]      trial;
    logic            ge;
    logic [W-1:0]    rem_sub;
    logic [W-1:0]    rem_nxt;
    logic [W-1:0]    dvd_nxt;
    logic [W-1:0]    q_fin;
    logic [W-1:0]    r_fin;

    assign accept      = (state == IDLE) && bus.start && !bus.flush;
    assign div_signed  = ~bus.op[0];
    assign div_by_zero = (bus.opb == '0);
    assign div_ovf     = div_signed && (bus.opa == {1'b1, {(W-1){1'b0}}}) && (bus.opb == '1);
    assign a_signed    = (bus.op == 3'b001) || (bus.op == 3'b010);
    assign b_signed    = (bus.op == 3'b001);
    assign cnt_last    = (cnt == CW'(W - 1));

    // Operands are held 33-bit sign/zero-extended so one signed multiply covers all four ops.
    assign ext_a   = {{(W-1){mul_a[W]}}, mul_a};
    assign ext_b   = {{(W-1){mul_b[W]}}, mul_b};
    assign product = ext_a * ext_b;

    // The shifted partial remainder needs one extra bit when the divisor exceeds 2^31.
    assign trial   = {rem, dvd[W-1]};
    assign ge      = (trial >= {1'b0, dvs});
    assign rem_sub = trial[W-1:0] - dvs;
    assign rem_nxt = ge ? rem_sub : trial[W-1:0];
    assign dvd_nxt = {dvd[W-2:0], ge};
    assign q_fin   = q_neg ? -dvd_nxt : dvd_nxt;
    assign r_fin   = r_neg ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus.op[2])                  state_nxt = MUL;
                    else if (div_by_zero || div_ovf) state_nxt = DONE;
                    else                             state_nxt = DIV;
                end
            end
            MUL:     state_nxt = DONE;
            DIV:     if (cnt_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_comb begin
        bus.stall = !reset && !bus.flush &&
                    (((state == IDLE) && bus.start) || (state == MUL) || (state == DIV));
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (!bus.flush) begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            op_q <= bus.op[1:0];
                            if (!bus.op[2]) begin
                                mul_a <= {a_signed & bus.opa[W-1], bus.opa};
                                mul_b <= {b_signed & bus.opb[W-1], bus.opb};
                            end else if (div_by_zero) begin
                                result_q <= bus.op[1] ? bus.opa : '1;
                                done_q   <= 1'b1;
                            end else if (div_ovf) begin
                                result_q <= bus.op[1] ? '0 : bus.opa;
                                done_q   <= 1'b1;
                            end else begin
                                dvd   <= (div_signed && bus.opa[W-1]) ? -bus.opa : bus.opa;
                                dvs   <= (div_signed && bus.opb[W-1]) ? -bus.opb : bus.opb;
                                rem   <= '0;
                                cnt   <= '0;
                                q_neg <= div_signed && (bus.opa[W-1] ^ bus.opb[W-1]);
                                r_neg <= div_signed && bus.opa[W-1];
                            end
                        end
                    end
                    MUL: begin
                        result_q <= (op_q == 2'b00) ? product[W-1:0] : product[2*W-1:W];
                        done_q   <= 1'b1;
                    end
                    DIV: begin
                        dvd <= dvd_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt_last) begin
                            result_q <= op_q[1] ? r_fin : q_fin;
                            done_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
